// File: rtl/mem_if_pkg.sv
// mem_if_pkg: FSM state codes, op-field slice bounds and access-kind encoding shared by mem_if
package mem_if_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  typedef enum logic [1:0] {K_IFETCH = 2'd0, K_RD = 2'd1, K_WR = 2'd2} kind_t;
  function automatic kind_t decode_kind(input logic irwrite, input logic memwrite);
    return memwrite ? K_WR : irwrite ? K_IFETCH : K_RD;
  endfunction
endpackage

// File: rtl/mem_timeout_ctr.sv
// mem_timeout_ctr: clearable bus-wait counter; clk, reset (sync active-low), clr, en in; tc high once TIMEOUT-1 is reached
module mem_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (!reset || clr) cnt <= '0;
    else if (en && !tc) cnt <= cnt + 1'b1;
  assign tc = cnt == LAST;
endmodule

// File: rtl/mem_if.sv
// mem_if: turns controller memory strobes (pc, aluout, wdata, iord, irwrite, memwrite) into one valid/ready bus transaction (bus_*), holds instr/op/mdr, drives stall, err, align_err
module mem_if
  import mem_if_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] aluout,
  input  logic [DATA_W-1:0] wdata,
  input  logic              iord,
  input  logic              irwrite,
  input  logic              memwrite,
  output logic              stall,
  output logic [DATA_W-1:0] instr,
  output logic [5:0]        op,
  output logic [DATA_W-1:0] mdr,
  output logic              bus_valid,
  output logic              bus_we,
  output logic [DATA_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ready,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              err,
  output logic              align_err
);
  logic [1:0] state;
  kind_t kind;
  logic req, tc;
  logic [DATA_W-1:0] addr_sel;
  assign req = irwrite | (iord & ~memwrite & ~irwrite) | memwrite;
  assign addr_sel = iord ? aluout : pc;
  assign stall = req & (state != S_DONE);
  assign bus_valid = state == S_BUS;
  assign bus_we = bus_valid & (kind == K_WR);
  assign op = instr[OP_HI:OP_LO];
  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
    .clk(clk),
    .reset(reset),
    .clr(state == S_IDLE),
    .en(bus_valid & ~bus_ready),
    .tc(tc)
  );
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      kind      <= K_IFETCH;
      instr     <= '0;
      mdr       <= '0;
      err       <= 1'b0;
      align_err <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else begin
      case (state)
        S_IDLE:
          if (req) begin
            bus_addr  <= {addr_sel[DATA_W-1:2], 2'b00};
            bus_wdata <= wdata;
            kind      <= decode_kind(irwrite, memwrite);
            align_err <= align_err | (|addr_sel[1:0]);
            state     <= S_BUS;
          end
        S_BUS:
          if (bus_ready) begin
            if (kind == K_IFETCH) instr <= bus_rdata;
            if (kind == K_RD) mdr <= bus_rdata;
            state <= S_DONE;
          end else if (tc) begin
            err   <= 1'b1;
            state <= S_DONE;
          end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_if.sv
// tb_mem_if: directed and random transactions on mem_if checked against a transaction-level model
module tb_mem_if;
  localparam int TO = 4;
  logic clk = 1'b0, reset = 1'b0;
  logic [31:0] pc = '0, aluout = '0, wdata = '0, bus_rdata = '0;
  logic iord = 1'b0, irwrite = 1'b0, memwrite = 1'b0, bus_ready = 1'b0;
  logic stall, bus_valid, bus_we, err, align_err;
  logic [31:0] instr, mdr, bus_addr, bus_wdata;
  logic [5:0] op;
  int checks = 0, failures = 0;
  logic [31:0] m_instr = '0, m_mdr = '0;
  logic m_err = 1'b0, m_align = 1'b0;

  mem_if #(.DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .pc(pc), .aluout(aluout), .wdata(wdata),
    .iord(iord), .irwrite(irwrite), .memwrite(memwrite), .stall(stall),
    .instr(instr), .op(op), .mdr(mdr), .bus_valid(bus_valid), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ready(bus_ready),
    .bus_rdata(bus_rdata), .err(err), .align_err(align_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, ".instr"}, instr, m_instr);
    chk({tag, ".op"}, {26'd0, op}, {26'd0, m_instr[31:26]});
    chk({tag, ".mdr"}, mdr, m_mdr);
    chk({tag, ".err"}, {31'd0, err}, {31'd0, m_err});
    chk({tag, ".align_err"}, {31'd0, align_err}, {31'd0, m_align});
  endtask

  // Drives one request at a negedge while the DUT is idle; the bus answers after
  // `waits` unready BUS cycles (never, if waits >= TO). Leaves the DUT idle again.
  task automatic run(input string tag, input logic irw, input logic io, input logic mw,
                     input logic [31:0] pcv, input logic [31:0] alv, input logic [31:0] wdv,
                     input logic [31:0] rdv, input int waits, input logic scramble);
    logic is_wr, is_fetch, is_rd, has_req, timed_out;
    logic [31:0] raw;
    int nbus;
    is_wr = mw;
    is_fetch = irw & ~mw;
    is_rd = io & ~mw & ~irw;
    has_req = irw | mw | io;
    raw = io ? alv : pcv;
    timed_out = waits >= TO;
    nbus = timed_out ? TO : waits + 1;
    irwrite = irw; iord = io; memwrite = mw; pc = pcv; aluout = alv; wdata = wdv;
    bus_ready = 1'b0;
    bus_rdata = $urandom;
    #1;
    chk({tag, ".stall0"}, {31'd0, stall}, {31'd0, has_req});
    chk({tag, ".valid0"}, {31'd0, bus_valid}, 32'd0);
    if (!has_req) begin
      @(negedge clk);
      chk({tag, ".idle_valid"}, {31'd0, bus_valid}, 32'd0);
      chk_regs(tag);
      return;
    end
    for (int k = 0; k < nbus; k++) begin
      @(negedge clk);
      bus_ready = (k == waits);
      bus_rdata = (k == waits) ? rdv : $urandom;
      if (scramble) begin pc = $urandom; aluout = $urandom; wdata = $urandom; end
      #1;
      chk({tag, ".bus_valid"}, {31'd0, bus_valid}, 32'd1);
      chk({tag, ".bus_we"}, {31'd0, bus_we}, {31'd0, is_wr});
      chk({tag, ".bus_addr"}, bus_addr, raw & ~32'h3);
      chk({tag, ".bus_wdata"}, bus_wdata, wdv);
      chk({tag, ".stall_bus"}, {31'd0, stall}, 32'd1);
    end
    if (timed_out) m_err = 1'b1;
    else if (is_fetch) m_instr = rdv;
    else if (is_rd) m_mdr = rdv;
    m_align = m_align | (|raw[1:0]);
    @(negedge clk);
    bus_ready = 1'b0;
    #1;
    chk({tag, ".stall_done"}, {31'd0, stall}, 32'd0);
    chk({tag, ".valid_done"}, {31'd0, bus_valid}, 32'd0);
    chk({tag, ".we_done"}, {31'd0, bus_we}, 32'd0);
    chk_regs(tag);
    irwrite = 1'b0; iord = 1'b0; memwrite = 1'b0;
    bus_ready = $urandom_range(0, 1);
    @(negedge clk);
    chk({tag, ".stall_idle"}, {31'd0, stall}, 32'd0);
    chk({tag, ".valid_idle"}, {31'd0, bus_valid}, 32'd0);
    chk_regs(tag);
    bus_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset.bus_valid", {31'd0, bus_valid}, 32'd0);
    chk("reset.bus_addr", bus_addr, 32'd0);
    chk("reset.bus_wdata", bus_wdata, 32'd0);
    chk("reset.stall", {31'd0, stall}, 32'd0);
    chk_regs("reset");
    reset = 1'b1;
    @(negedge clk);
    run("fetch0", 1, 0, 0, 32'h40, 32'h0, 32'h0, 32'h8C08_0004, 0, 0);
    chk("fetch0.op", {26'd0, op}, 32'h23);
    run("load3", 0, 1, 0, 32'h44, 32'h104, 32'h0, 32'hDEAD_BEEF, 3, 0);
    run("store", 0, 1, 1, 32'h48, 32'h200, 32'h1234_5678, 32'hFFFF_FFFF, 2, 0);
    run("timeout", 1, 0, 0, 32'h4C, 32'h0, 32'h0, 32'h1111_2222, 100, 0);
    run("after_to", 1, 0, 0, 32'h50, 32'h0, 32'h0, 32'h2222_3333, 1, 0);
    run("misalign", 0, 1, 0, 32'h54, 32'h203, 32'h0, 32'h3333_4444, 2, 1);
    run("nothing", 0, 0, 0, 32'h58, 32'h0, 32'h0, 32'h0, 0, 0);
    // reset while a transaction sits in BUS with the request still asserted
    irwrite = 1'b1; pc = 32'h60;
    @(negedge clk);
    chk("rst_mid.in_bus", {31'd0, bus_valid}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    m_instr = '0; m_mdr = '0; m_err = 1'b0; m_align = 1'b0;
    chk("rst_mid.valid", {31'd0, bus_valid}, 32'd0);
    chk("rst_mid.we", {31'd0, bus_we}, 32'd0);
    chk("rst_mid.addr", bus_addr, 32'd0);
    chk("rst_mid.stall", {31'd0, stall}, 32'd1);
    chk_regs("rst_mid");
    reset = 1'b1; irwrite = 1'b0;
    @(negedge clk);
    run("post_rst", 1, 0, 0, 32'h64, 32'h0, 32'h0, 32'hAC09_0008, 0, 0);
    for (int i = 0; i < 30; i++)
      run("rand", 1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
          $urandom, int'($urandom_range(0, 5)), 1'($urandom));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
